// File: rtl/wave_meas_pkg.sv
// Shared FSM encoding, Schmitt state constants and the saturating increment
// used by the waveform measurement engine.
package wave_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_MEAS  = 2'd2,
    ST_LATCH = 2'd3
  } meas_state_t;

  localparam logic SCH_LOW  = 1'b0;
  localparam logic SCH_HIGH = 1'b1;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] lim;
    lim = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= lim) ? lim : (value + 32'd1);
  endfunction

endpackage

// File: rtl/median3_filt.sv
// 3-tap median spike filter; dout is combinational with the third and later strobes.
// No backpressure: every in_valid is accepted; the first two after clr only fill history.
module median3_filt #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] h0;
  logic [DW-1:0] h1;
  logic [1:0]    fill;
  logic [DW-1:0] lo01;
  logic [DW-1:0] hi01;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      h0   <= '0;
      h1   <= '0;
      fill <= 2'd0;
    end else if (in_valid) begin
      h1 <= h0;
      h0 <= din;
      if (fill != 2'd2) begin
        fill <= fill + 2'd1;
      end
    end
  end

  // Median = new sample clamped into the range spanned by the two history taps.
  always_comb begin
    lo01 = (h0 < h1) ? h0 : h1;
    hi01 = (h0 < h1) ? h1 : h0;
    if (din <= lo01) begin
      dout = lo01;
    end else if (din >= hi01) begin
      dout = hi01;
    end else begin
      dout = din;
    end
  end

  assign out_valid = in_valid && (fill == 2'd2);

endmodule

// File: rtl/wave_meas.sv
// Gated max/min/p-p, hysteresis edge count and edge span on median-filtered samples.
// Results latch one cycle after the gate closes with a meas_valid pulse; no backpressure.
module wave_meas
  import wave_meas_pkg::*;
#(
  parameter int DW          = 12,
  parameter int GATE_CYCLES = 5_000_000,
  parameter int MID         = 2048,
  parameter int HYST        = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [DW-1:0]    din,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             meas_valid,
  output logic [DW-1:0]    vmax,
  output logic [DW-1:0]    vmin,
  output logic [DW-1:0]    vpp,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] span_cyc,
  output logic             no_signal
);

  localparam int          GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [DW:0] TH_HI     = (DW+1)'(MID + HYST);
  localparam logic [DW:0] TH_LO     = (DW+1)'(MID - HYST);

  meas_state_t      state;
  meas_state_t      nstate;
  logic [GW-1:0]    gate_cnt;
  logic             gate_end;

  logic             f_vld;
  logic [DW-1:0]    f_dat;
  logic             rise;
  logic             fall;

  logic [DW-1:0]    acc_max;
  logic [DW-1:0]    acc_min;
  logic             acc_any;
  logic             sch;
  logic [CNT_W-1:0] edge_acc;
  logic             span_on;
  logic [CNT_W-1:0] span_run;
  logic [CNT_W-1:0] span_last;

  median3_filt #(
    .DW(DW)
  ) u_filt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == ST_ARM),
    .in_valid (din_valid && (state == ST_MEAS)),
    .din      (din),
    .out_valid(f_vld),
    .dout     (f_dat)
  );

  assign gate_end = (gate_cnt == GATE_LAST);
  assign rise     = f_vld && (sch == SCH_LOW)  && ({1'b0, f_dat} >= TH_HI);
  assign fall     = f_vld && (sch == SCH_HIGH) && ({1'b0, f_dat} <= TH_LO);

  // busy also covers LATCH when re-arming, so continuous mode never shows idle.
  always_comb begin
    nstate = state;
    busy   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          nstate = ST_ARM;
        end
      end
      ST_ARM: begin
        busy   = 1'b1;
        nstate = ST_MEAS;
      end
      ST_MEAS: begin
        busy = 1'b1;
        if (gate_end) begin
          nstate = ST_LATCH;
        end
      end
      ST_LATCH: begin
        busy   = cont;
        nstate = cont ? ST_ARM : ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Gate counter and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt  <= '0;
      acc_max   <= '0;
      acc_min   <= '1;
      acc_any   <= 1'b0;
      sch       <= SCH_LOW;
      edge_acc  <= '0;
      span_on   <= 1'b0;
      span_run  <= '0;
      span_last <= '0;
    end else if (state == ST_ARM) begin
      gate_cnt  <= '0;
      acc_max   <= '0;
      acc_min   <= '1;
      acc_any   <= 1'b0;
      sch       <= SCH_LOW;
      edge_acc  <= '0;
      span_on   <= 1'b0;
      span_run  <= '0;
      span_last <= '0;
    end else if (state == ST_MEAS) begin
      gate_cnt <= gate_end ? '0 : gate_cnt + GW'(1);
      if (f_vld) begin
        acc_any <= 1'b1;
        if (f_dat >= acc_max) begin
          acc_max <= f_dat;
        end
        if (f_dat <= acc_min) begin
          acc_min <= f_dat;
        end
      end
      if (rise) begin
        sch      <= SCH_HIGH;
        edge_acc <= CNT_W'(sat_inc(32'(edge_acc), CNT_W));
      end else if (fall) begin
        sch <= SCH_LOW;
      end
      // span_run reads k on the k-th cycle after the first rising edge.
      if (span_on || rise) begin
        span_run <= CNT_W'(sat_inc(32'(span_run), CNT_W));
      end
      if (rise) begin
        span_on <= 1'b1;
        if (span_on) begin
          span_last <= span_run;
        end
      end
    end
  end

  // Result registers update together and hold until the next LATCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_valid <= 1'b0;
      vmax       <= '0;
      vmin       <= '0;
      vpp        <= '0;
      edge_cnt   <= '0;
      span_cyc   <= '0;
      no_signal  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (state == ST_LATCH) begin
        meas_valid <= 1'b1;
        if (acc_any) begin
          vmax      <= acc_max;
          vmin      <= acc_min;
          vpp       <= acc_max - acc_min;
          edge_cnt  <= edge_acc;
          span_cyc  <= span_last;
          no_signal <= 1'b0;
        end else begin
          vmax      <= '0;
          vmin      <= '0;
          vpp       <= '0;
          edge_cnt  <= '0;
          span_cyc  <= '0;
          no_signal <= 1'b1;
        end
      end
    end
  end

endmodule
